// File: rtl/conv_accumulator_if.sv
`default_nettype none
// ============================================================================
//  Module      : conv_accumulator_if
//  Description : Bundle of job, beat and result signals shared by the
//                upstream window/weight fetch logic (master) and the
//                per-channel MAC accumulator (slave).
//                  start/len/bias           : job launch (master -> slave)
//                  act_in/wgt_in/in_valid   : MAC beat    (master -> slave)
//                  in_ready                 : beat accept (slave -> master)
//                  acc_out/acc_valid/
//                  busy/sat_flag            : result/status (slave -> master)
//  Revision    : 1.0 - initial release
// ============================================================================
interface conv_accumulator_if #(
   parameter int IN_W   = 8,
   parameter int ACC_W  = 32,
   parameter int OUT_CH = 16,
   parameter int LEN_W  = 16
);
   logic                              start;
   logic [LEN_W-1:0]                  len;
   logic [OUT_CH-1:0][ACC_W-1:0]      bias;
   logic [IN_W-1:0]                   act_in;
   logic [OUT_CH-1:0][IN_W-1:0]       wgt_in;
   logic                              in_valid;
   logic                              in_ready;
   logic [OUT_CH-1:0][ACC_W-1:0]      acc_out;
   logic                              acc_valid;
   logic                              busy;
   logic                              sat_flag;

   modport master (
      output start, len, bias, act_in, wgt_in, in_valid,
      input  in_ready, acc_out, acc_valid, busy, sat_flag
   );

   modport slave (
      input  start, len, bias, act_in, wgt_in, in_valid,
      output in_ready, acc_out, acc_valid, busy, sat_flag
   );
endinterface
`default_nettype wire

// File: rtl/conv_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : conv_accumulator
//  Description : Per-channel saturating MAC accumulator. A job preloads
//                OUT_CH signed biases, accumulates len beats of
//                act_in * wgt_in[c] per channel with per-step clamping, and
//                emits one OUT_CH x ACC_W result with a one-cycle acc_valid.
//  Ports       : clk  - clock
//                rst  - asynchronous active-high reset
//                bus  - conv_accumulator_if.slave (job, beat, result, status)
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_accumulator #(
   parameter int IN_W   = 8,
   parameter int ACC_W  = 32,
   parameter int OUT_CH = 16,
   parameter int LEN_W  = 16
) (
   input  wire logic             clk,
   input  wire logic             rst,
   conv_accumulator_if.slave     bus
);

   localparam logic [ACC_W-1:0] C_ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] C_ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
   localparam logic [LEN_W-1:0] C_ONE     = {{(LEN_W-1){1'b0}}, 1'b1};

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_ACCUM = 1'b1
   } state_t;

   state_t                        state_q, state_d;
   logic [OUT_CH-1:0][ACC_W-1:0]  acc_q, acc_d;
   logic [OUT_CH-1:0][ACC_W-1:0]  acc_out_q, acc_out_d;
   logic [LEN_W-1:0]              count_q, count_d;
   logic [LEN_W-1:0]              len_q, len_d;
   logic                          sat_q, sat_d;          // running sticky flag
   logic                          sat_flag_q, sat_flag_d; // published with result
   logic                          acc_valid_q, acc_valid_d;
   logic                          in_ready_q, in_ready_d;
   logic                          busy_q, busy_d;

   logic [OUT_CH-1:0][ACC_W-1:0]  w_acc_next;
   logic [OUT_CH-1:0]             w_ch_sat;
   logic                          w_any_sat;
   logic                          w_last;

   // Per-channel product, widened add and clamp. The add is one bit wider
   // than the accumulator so overflow shows up as a mismatch of the top two
   // bits; the top bit then selects which rail to clamp to.
   for (genvar c = 0; c < OUT_CH; c++) begin : g_ch
      logic [2*IN_W-1:0] w_act_ext;
      logic [2*IN_W-1:0] w_wgt_ext;
      logic [2*IN_W-1:0] w_prod;
      logic [ACC_W:0]    w_sum;

      assign w_act_ext = {{IN_W{bus.act_in[IN_W-1]}}, bus.act_in};
      assign w_wgt_ext = {{IN_W{bus.wgt_in[c][IN_W-1]}}, bus.wgt_in[c]};
      // Low 2*IN_W bits of the product of sign-extended operands are the
      // exact signed product.
      assign w_prod    = w_act_ext * w_wgt_ext;
      assign w_sum     = {acc_q[c][ACC_W-1], acc_q[c]}
                       + {{(ACC_W+1-2*IN_W){w_prod[2*IN_W-1]}}, w_prod};
      assign w_ch_sat[c]   = w_sum[ACC_W] ^ w_sum[ACC_W-1];
      assign w_acc_next[c] = !w_ch_sat[c] ? w_sum[ACC_W-1:0]
                           : (w_sum[ACC_W] ? C_ACC_MIN : C_ACC_MAX);
   end

   assign w_any_sat = |w_ch_sat;
   // len_q is never zero in ST_ACCUM, so len_q-1 cannot wrap; count_q never
   // exceeds len_q-1, so a full-scale length cannot overflow the counter.
   assign w_last    = (count_q == (len_q - C_ONE));

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      acc_out_d   = acc_out_q;
      count_d     = count_q;
      len_d       = len_q;
      sat_d       = sat_q;
      sat_flag_d  = sat_flag_q;
      acc_valid_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               if (bus.len == '0) begin
                  // Empty job: the bias itself is the result.
                  acc_out_d   = bus.bias;
                  acc_valid_d = 1'b1;
                  sat_flag_d  = 1'b0;
               end else begin
                  acc_d   = bus.bias;
                  count_d = '0;
                  len_d   = bus.len;
                  sat_d   = 1'b0;
                  state_d = ST_ACCUM;
               end
            end
         end
         ST_ACCUM: begin
            if (bus.in_valid) begin
               acc_d = w_acc_next;
               sat_d = sat_q | w_any_sat;
               if (w_last) begin
                  acc_out_d   = w_acc_next;
                  acc_valid_d = 1'b1;
                  sat_flag_d  = sat_q | w_any_sat;
                  state_d     = ST_IDLE;
               end else begin
                  count_d = count_q + C_ONE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Status outputs are registered from the next state.
      in_ready_d = (state_d == ST_ACCUM);
      busy_d     = (state_d == ST_ACCUM);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         acc_q       <= '0;
         acc_out_q   <= '0;
         count_q     <= '0;
         len_q       <= '0;
         sat_q       <= 1'b0;
         sat_flag_q  <= 1'b0;
         acc_valid_q <= 1'b0;
         in_ready_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         acc_out_q   <= acc_out_d;
         count_q     <= count_d;
         len_q       <= len_d;
         sat_q       <= sat_d;
         sat_flag_q  <= sat_flag_d;
         acc_valid_q <= acc_valid_d;
         in_ready_q  <= in_ready_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.acc_out   = acc_out_q;
   assign bus.acc_valid = acc_valid_q;
   assign bus.sat_flag  = sat_flag_q;
   assign bus.in_ready  = in_ready_q;
   assign bus.busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv_accumulator
//  Description : Self-checking bench for conv_accumulator. Jobs are driven
//                from a stimulus process; each job's expected result comes
//                from an arithmetic reference model and is queued, and a
//                monitor pops and compares on every acc_valid.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_accumulator;

   localparam int IN_W   = 8;
   localparam int ACC_W  = 32;
   localparam int OUT_CH = 16;
   localparam int LEN_W  = 16;

   localparam longint ACC_MAX_L = 2147483647;
   localparam longint ACC_MIN_L = -ACC_MAX_L - 1;

   typedef logic [IN_W-1:0]                  act_t;
   typedef logic [OUT_CH-1:0][IN_W-1:0]      wvec_t;
   typedef logic [OUT_CH-1:0][ACC_W-1:0]     avec_t;
   typedef struct packed {
      avec_t acc;
      logic  sat;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;

   conv_accumulator_if #(.IN_W(IN_W), .ACC_W(ACC_W), .OUT_CH(OUT_CH), .LEN_W(LEN_W)) bus ();

   conv_accumulator #(.IN_W(IN_W), .ACC_W(ACC_W), .OUT_CH(OUT_CH), .LEN_W(LEN_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];
   exp_t last_exp;
   exp_t mon_e;
   act_t  job_act[$];
   wvec_t job_wgt[$];

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", name, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: start from bias, add each product as a 64-bit integer and
   // clamp back into the int32 range after every beat.
   function automatic exp_t model(input avec_t b);
      exp_t   r;
      longint acc [OUT_CH];
      r.sat = 1'b0;
      for (int c = 0; c < OUT_CH; c++) acc[c] = longint'($signed(b[c]));
      for (int i = 0; i < job_act.size(); i++) begin
         for (int c = 0; c < OUT_CH; c++) begin
            acc[c] += longint'($signed(job_act[i])) * longint'($signed(job_wgt[i][c]));
            if (acc[c] > ACC_MAX_L) begin acc[c] = ACC_MAX_L; r.sat = 1'b1; end
            if (acc[c] < ACC_MIN_L) begin acc[c] = ACC_MIN_L; r.sat = 1'b1; end
         end
      end
      for (int c = 0; c < OUT_CH; c++) r.acc[c] = acc[c][ACC_W-1:0];
      return r;
   endfunction

   task automatic fill_random(input int n);
      wvec_t w;
      job_act.delete();
      job_wgt.delete();
      for (int i = 0; i < n; i++) begin
         job_act.push_back(act_t'($urandom));
         for (int c = 0; c < OUT_CH; c++) w[c] = act_t'($urandom);
         job_wgt.push_back(w);
      end
   endtask

   function automatic avec_t rand_bias();
      avec_t b;
      for (int c = 0; c < OUT_CH; c++) begin
         case ($urandom_range(0, 3))
            0:       b[c] = 32'h7FFF_C000 + 32'($urandom_range(0, 'h3FFF));
            1:       b[c] = 32'h8000_0000 + 32'($urandom_range(0, 'h3FFF));
            default: b[c] = 32'($signed(16'($urandom)));
         endcase
      end
      return b;
   endfunction

   // Runs the job currently held in job_act/job_wgt. Returns right after the
   // edge that produced the result, i.e. inside the acc_valid cycle, so the
   // caller may launch the next job immediately.
   task automatic run_job(input avec_t b, input bit gaps);
      int   n;
      exp_t e;
      n = job_act.size();
      e = model(b);
      exp_q.push_back(e);
      last_exp = e;
      bus.start    = 1'b1;
      bus.len      = LEN_W'(n);
      bus.bias     = b;
      bus.in_valid = 1'b0;
      tick();
      bus.start = 1'b0;
      if (n == 0) begin
         chk("zero_len_valid", 64'(bus.acc_valid), 64'd1);
         chk("zero_len_busy", 64'(bus.busy), 64'd0);
         return;
      end
      chk("accum_busy", 64'(bus.busy), 64'd1);
      chk("accum_in_ready", 64'(bus.in_ready), 64'd1);
      for (int i = 0; i < n; i++) begin
         while (gaps && $urandom_range(0, 2) == 0) begin
            // Bubble cycle, with a stray start carrying a different job.
            bus.in_valid = 1'b0;
            bus.start    = 1'($urandom);
            bus.len      = LEN_W'($urandom);
            bus.bias     = rand_bias();
            bus.act_in   = act_t'($urandom);
            tick();
            chk("gap_in_ready", 64'(bus.in_ready), 64'd1);
         end
         bus.start    = 1'b0;
         bus.in_valid = 1'b1;
         bus.act_in   = job_act[i];
         bus.wgt_in   = job_wgt[i];
         tick();
         bus.in_valid = 1'b0;
         if (i < n - 1 && n < 100) chk("early_valid", 64'(bus.acc_valid), 64'd0);
      end
      chk("done_valid", 64'(bus.acc_valid), 64'd1);
      chk("done_busy", 64'(bus.busy), 64'd0);
      chk("done_in_ready", 64'(bus.in_ready), 64'd0);
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         bus.start    = 1'b0;
         bus.in_valid = 1'($urandom);
         bus.act_in   = act_t'($urandom);
         tick();
         chk("idle_no_valid", 64'(bus.acc_valid), 64'd0);
      end
      bus.in_valid = 1'b0;
   endtask

   // Scoreboard monitor.
   always @(negedge clk) begin
      if (!rst && bus.acc_valid) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_result got acc_valid=1 want no emission");
         end else begin
            mon_e = exp_q.pop_front();
            if (bus.acc_out !== mon_e.acc || bus.sat_flag !== mon_e.sat) begin
               errors++;
               $display("FAIL result got acc=%h sat=%0d want acc=%h sat=%0d",
                        bus.acc_out, bus.sat_flag, mon_e.acc, mon_e.sat);
            end
         end
      end
   end

   initial begin
      avec_t b;
      wvec_t w;

      bus.start = 1'b0; bus.len = '0; bus.bias = '0;
      bus.act_in = '0; bus.wgt_in = '0; bus.in_valid = 1'b0;

      #2 rst = 1'b1;
      #1;
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
      chk("rst_acc_valid", 64'(bus.acc_valid), 64'd0);
      chk("rst_sat_flag", 64'(bus.sat_flag), 64'd0);
      chk("rst_acc_out_any", 64'(|bus.acc_out), 64'd0);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      tick();

      // Basic job.
      for (int c = 0; c < OUT_CH; c++) b[c] = 32'd10;
      w = '0; w[0] = 8'd2; w[5] = 8'hFF;
      job_act.delete(); job_wgt.delete();
      for (int i = 1; i <= 3; i++) begin job_act.push_back(act_t'(i)); job_wgt.push_back(w); end
      run_job(b, 1'b0);
      chk("basic_ch0", 64'(bus.acc_out[0]), 64'd22);
      chk("basic_ch5", 64'(bus.acc_out[5]), 64'd4);
      chk("basic_sat", 64'(bus.sat_flag), 64'd0);
      idle_cycles(2);

      // Same job with bubbles and stray starts.
      run_job(b, 1'b1);
      chk("bubble_ch0", 64'(bus.acc_out[0]), 64'd22);
      chk("bubble_ch5", 64'(bus.acc_out[5]), 64'd4);
      idle_cycles(1);

      // Zero length.
      for (int c = 0; c < OUT_CH; c++) b[c] = 32'(100 * c);
      job_act.delete(); job_wgt.delete();
      run_job(b, 1'b0);
      chk("zero_len_ch7", 64'(bus.acc_out[7]), 64'd700);
      chk("zero_len_ch15", 64'(bus.acc_out[15]), 64'd1500);
      idle_cycles(1);

      // Positive saturation.
      for (int c = 0; c < OUT_CH; c++) begin b[c] = 32'h7FFF_FF00; w[c] = 8'd127; end
      job_act.delete(); job_wgt.delete();
      for (int i = 0; i < 2; i++) begin job_act.push_back(8'd127); job_wgt.push_back(w); end
      run_job(b, 1'b0);
      chk("sat_pos_ch3", 64'(bus.acc_out[3]), 64'h7FFF_FFFF);
      chk("sat_pos_flag", 64'(bus.sat_flag), 64'd1);
      idle_cycles(1);

      // Negative saturation.
      for (int c = 0; c < OUT_CH; c++) b[c] = 32'h8000_0064;
      job_act.delete(); job_wgt.delete();
      job_act.push_back(8'h80); job_wgt.push_back(w);
      run_job(b, 1'b0);
      chk("sat_neg_ch9", 64'(bus.acc_out[9]), 64'h8000_0000);
      chk("sat_neg_flag", 64'(bus.sat_flag), 64'd1);

      // Clean job launched in the acc_valid cycle must clear the flag.
      fill_random(2);
      run_job('0, 1'b0);
      chk("clean_after_sat_flag", 64'(bus.sat_flag), 64'd0);

      // in_valid pulses in IDLE change nothing.
      idle_cycles(4);
      checks++;
      if (bus.acc_out !== last_exp.acc || bus.sat_flag !== last_exp.sat) begin
         errors++;
         $display("FAIL idle_hold got acc=%h want acc=%h", bus.acc_out, last_exp.acc);
      end

      // Random jobs, some back-to-back.
      for (int j = 0; j < 24; j++) begin
         fill_random($urandom_range(0, 8));
         run_job(rand_bias(), 1'($urandom));
         idle_cycles($urandom_range(0, 2));
      end

      // Reset in the middle of a 5-beat job.
      fill_random(5);
      bus.start = 1'b1; bus.len = 16'd5; bus.bias = rand_bias(); bus.in_valid = 1'b0;
      tick();
      bus.start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         bus.in_valid = 1'b1; bus.act_in = job_act[i]; bus.wgt_in = job_wgt[i];
         tick();
      end
      bus.in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("abort_busy", 64'(bus.busy), 64'd0);
      chk("abort_in_ready", 64'(bus.in_ready), 64'd0);
      chk("abort_acc_valid", 64'(bus.acc_valid), 64'd0);
      chk("abort_acc_out_any", 64'(|bus.acc_out), 64'd0);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      tick();
      fill_random(3);
      run_job(rand_bias(), 1'b1);
      idle_cycles(1);

      // Full-scale length.
      fill_random((1 << LEN_W) - 1);
      run_job('0, 1'b0);
      idle_cycles(3);

      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
